spi_word_receiver: RTL and testbench
====================================

# spi_word_receiver

SPI mode-0 slave that deserialises 16-bit command words from the host MCU and presents them to the PWM channel block. Each word is `{address[15:8], duty[7:0]}`. The block drives `byte_data_received` and a one-cycle `byte_received` strobe, which the PWM block decodes directly. MISO echoes the most recently completed word so the host can read back what was accepted.

## Interface
- `WORD_W`, default 16: bits per word; the PWM block requires 16.
- `SYNC_STAGES`, default 2: flip-flop depth of every pin synchroniser; minimum 2.

Ports:
- `clk50M` in 1: system clock, 50 MHz.
- `rst_n` in 1: reset, asynchronous, active-low.
- `spi_sck` in 1: SPI clock from host; idles low; asynchronous to `clk50M`.
- `spi_mosi` in 1: host data, MSB first; valid at SCK rise.
- `spi_cs_n` in 1: chip select, active-low.
- `spi_miso` out 1: echo data, changes after SCK fall.
- `byte_data_received` out WORD_W: last completed word; held until the next word completes.
- `byte_received` out 1: one-cycle pulse when `byte_data_received` updates.
- `frame_error` out 1: one-cycle pulse when CS deasserts mid-word.

## Operation
- Synchronisation:
  - `spi_sck`, `spi_mosi` and `spi_cs_n` each pass through SYNC_STAGES flops of identical depth, so relative ordering is preserved.
  - Reset values of the chains: sck 0, mosi 0, cs_n 1.
  - A further flop on synced sck gives `rise` = s_sck & ~sck_d and `fall` = ~s_sck & sck_d.
- States: IDLE (s_cs_n=1) and SHIFT (s_cs_n=0). There is no other state; the bit counter `bit_cnt` (0..WORD_W-1) tracks position.
- IDLE → SHIFT on s_cs_n falling:
  - `bit_cnt`←0.
  - `tx_shift`←`byte_data_received`.
- SHIFT, `rise`:
  - `rx_shift`←{rx_shift[WORD_W-2:0], s_mosi}.
  - `bit_cnt`+1.
- SHIFT, `rise` with `bit_cnt`=WORD_W-1:
  - `byte_data_received`←{rx_shift[WORD_W-2:0], s_mosi}.
  - `byte_received`←1 for one cycle.
  - `tx_shift`←the same completed word.
  - `bit_cnt` wraps to 0. Back-to-back words within one CS frame are legal.
- SHIFT, `fall` with `bit_cnt`≠0: `tx_shift` shifts left by one, filling with 0. A fall with `bit_cnt`=0 (after a word boundary) does not shift.
- `spi_miso` = `tx_shift[WORD_W-1]` while in SHIFT; 0 in IDLE.
- SHIFT → IDLE on s_cs_n rising:
  - If `bit_cnt`≠0: partial word discarded, `frame_error` pulses for one cycle, `byte_data_received` unchanged.
  - If `bit_cnt`=0: no error.
- Simultaneous events:
  - A `rise` is processed only when s_cs_n=0 in the same cycle.
  - `rise` and `fall` are mutually exclusive by construction.
  - `byte_received` and `frame_error` never assert in the same cycle.
- No address decoding happens here. All words are forwarded, including addresses the PWM block ignores.

## Timing
- Reset values (asynchronous on `rst_n`=0):
  - `byte_data_received`=0, `byte_received`=0, `frame_error`=0, `spi_miso`=0.
  - `bit_cnt`=0, `rx_shift`=0, `tx_shift`=0, state IDLE.
- Reset mid-word: the partial word is lost and no `frame_error` is raised. After release, reception resumes at the next CS falling edge.
- Latency: the last SCK rise is first sampled high at clk edge E. `byte_received` is high in the cycle after edge E+SYNC_STAGES (3 cycles for the default).
- `byte_received` is exactly one `clk50M` cycle wide; `byte_data_received` is valid in that cycle and stays stable afterwards.
- SCK limit: ≤ `clk50M`/10 (5 MHz). High and low phases ≥ 5 clk cycles each.
- Host timing requirements:
  - CS setup ≥ 5 clk cycles before the first SCK rise.
  - CS hold ≥ 5 clk cycles after the last SCK fall.
  - MOSI setup/hold ≥ 3 clk cycles around each rise.
- MISO update delay: ≤ SYNC_STAGES+2 clk cycles after the SCK fall or CS fall at the pin.

## Test plan
- Reset: hold `rst_n`=0 for 10 cycles with SCK toggling → all outputs 0 and no pulses; release → still 0.
- Single word: CS low, shift 0x01A5 at 5 MHz, CS high → exactly one `byte_received` pulse, `byte_data_received`=0x01A5, `frame_error` never asserted.
- Back-to-back: one CS frame carrying 0x0240 then 0x03FF → two pulses, with data 0x0240 then 0x03FF. Latency from each 16th sampled rise is 3 cycles.
- Abort: send 9 bits of 0x02xx, then CS high → one `frame_error` pulse, no `byte_received`, data holds 0x03FF. A following full word 0x0110 is received correctly.
- Echo: after 0x01A5 is accepted, the next frame sends 0x0000 → host reads 0x01A5 on MISO. A second word in the same frame reads back 0x0000.
- Reset mid-word: assert `rst_n` low after 8 bits → outputs return to 0. After release, a full word 0x0310 gives one pulse with data 0x0310.

Source files
------------

// File: rtl/spi_word_receiver.sv
// SPI mode-0 slave: deserialises WORD_W-bit words MSB first, strobes each completed word,
// and echoes the most recently completed word back on MISO.
module spi_word_receiver #(
   parameter int WORD_W      = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk50M,
   input  logic              rst_n,
   input  logic              spi_sck,
   input  logic              spi_mosi,
   input  logic              spi_cs_n,
   output logic              spi_miso,
   output logic [WORD_W-1:0] byte_data_received,
   output logic              byte_received,
   output logic              frame_error
);

   localparam int CNT_W = (WORD_W > 2) ? $clog2(WORD_W) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t                 state, state_next;
   logic [SYNC_STAGES-1:0] sck_sync, mosi_sync, cs_sync;
   logic                   sck_d;
   logic                   s_sck, s_mosi, s_cs_n, rise, fall;
   logic [CNT_W-1:0]       bit_cnt, cnt_next;
   logic [WORD_W-1:0]      rx_shift, rx_next, tx_shift, tx_next, data_next;
   logic                   br_next, fe_next;

   // All three pins use chains of the same depth so their relative ordering survives.
   always_ff @(posedge clk50M or negedge rst_n) begin
      if (!rst_n) begin
         sck_sync  <= '0;
         mosi_sync <= '0;
         cs_sync   <= '1;
         sck_d     <= 1'b0;
      end else begin
         sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
         sck_d     <= sck_sync[SYNC_STAGES-1];
      end
   end

   assign s_sck  = sck_sync[SYNC_STAGES-1];
   assign s_mosi = mosi_sync[SYNC_STAGES-1];
   assign s_cs_n = cs_sync[SYNC_STAGES-1];
   assign rise   = s_sck & ~sck_d;
   assign fall   = ~s_sck & sck_d;

   always_comb begin
      state_next = state;
      cnt_next   = bit_cnt;
      rx_next    = rx_shift;
      tx_next    = tx_shift;
      data_next  = byte_data_received;
      br_next    = 1'b0;
      fe_next    = 1'b0;
      case (state)
         IDLE: begin
            if (!s_cs_n) begin
               state_next = SHIFT;
               cnt_next   = '0;
               tx_next    = byte_data_received;
            end
         end
         SHIFT: begin
            if (s_cs_n) begin
               state_next = IDLE;
               fe_next    = (bit_cnt != '0);
               cnt_next   = '0;
            end else if (rise) begin
               rx_next = {rx_shift[WORD_W-2:0], s_mosi};
               if (bit_cnt == LAST_BIT) begin
                  cnt_next  = '0;
                  data_next = rx_next;
                  tx_next   = rx_next;
                  br_next   = 1'b1;
               end else begin
                  cnt_next = bit_cnt + CNT_W'(1);
               end
            end else if (fall && bit_cnt != '0) begin
               // The fall right after a word boundary keeps the new echo word's MSB on the line.
               tx_next = {tx_shift[WORD_W-2:0], 1'b0};
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk50M or negedge rst_n) begin
      if (!rst_n) begin
         state              <= IDLE;
         bit_cnt            <= '0;
         rx_shift           <= '0;
         tx_shift           <= '0;
         byte_data_received <= '0;
         byte_received      <= 1'b0;
         frame_error        <= 1'b0;
      end else begin
         state              <= state_next;
         bit_cnt            <= cnt_next;
         rx_shift           <= rx_next;
         tx_shift           <= tx_next;
         byte_data_received <= data_next;
         byte_received      <= br_next;
         frame_error        <= fe_next;
      end
   end

   assign spi_miso = (state == SHIFT) & tx_shift[WORD_W-1];

endmodule

// File: tb/tb_spi_word_receiver.sv
// Bench for spi_word_receiver: table of frames, reset corner cases, then random frames
// checked against a word-level model of what the host should see.
module tb_spi_word_receiver;

   logic        clk50M = 1'b0;
   logic        rst_n  = 1'b0;
   logic        spi_sck = 1'b0;
   logic        spi_mosi = 1'b0;
   logic        spi_cs_n = 1'b1;
   logic        spi_miso;
   logic [15:0] byte_data_received;
   logic        byte_received;
   logic        frame_error;

   spi_word_receiver #(.WORD_W(16), .SYNC_STAGES(2)) dut (
      .clk50M(clk50M),
      .rst_n(rst_n),
      .spi_sck(spi_sck),
      .spi_mosi(spi_mosi),
      .spi_cs_n(spi_cs_n),
      .spi_miso(spi_miso),
      .byte_data_received(byte_data_received),
      .byte_received(byte_received),
      .frame_error(frame_error)
   );

   // Clock / reset / bookkeeping
   always #10 clk50M = ~clk50M;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc = 0;
   int last_rise_cyc = 0;
   int br_cnt = 0;
   int fe_cnt = 0;
   int proto_err = 0;

   logic [15:0] exp_q[$];
   logic [15:0] got_q[$];
   int          lat_q[$];
   logic [15:0] frame_w[4];
   logic [15:0] frame_echo[4];
   logic [15:0] exp_echo[4];

   always @(posedge clk50M) cyc <= cyc + 1;

   initial begin
      #1800us;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Monitor: collects strobes, latency, and pulse-shape violations
   logic        prev_br = 1'b0, prev_fe = 1'b0, prev_rst = 1'b0;
   logic [15:0] held = '0;
   always @(negedge clk50M) begin
      if (byte_received) begin
         br_cnt++;
         got_q.push_back(byte_data_received);
         lat_q.push_back(cyc - last_rise_cyc);
      end
      if (frame_error) fe_cnt++;
      if (byte_received && frame_error) proto_err++;
      if (byte_received && prev_br) proto_err++;
      if (frame_error && prev_fe) proto_err++;
      if (rst_n && prev_rst && !byte_received && byte_data_received !== held) proto_err++;
      held     = byte_data_received;
      prev_br  = byte_received;
      prev_fe  = frame_error;
      prev_rst = rst_n;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Driver tasks
   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk50M);
      #1;
   endtask

   task automatic spi_bits(input logic [15:0] w, input int n, output logic [15:0] echo);
      echo = '0;
      for (int i = 0; i < n; i++) begin
         spi_mosi = w[15-i];
         wait_clk($urandom_range(5, 7));
         echo[15-i] = spi_miso;
         spi_sck = 1'b1;
         last_rise_cyc = cyc;
         wait_clk($urandom_range(5, 7));
         spi_sck = 1'b0;
      end
   endtask

   task automatic run_frame(input int nfull, input int part);
      logic [15:0] e;
      spi_cs_n = 1'b0;
      wait_clk(6);
      for (int k = 0; k < nfull; k++) begin
         spi_bits(frame_w[k], 16, e);
         frame_echo[k] = e;
      end
      if (part > 0) spi_bits(frame_w[nfull], part, e);
      wait_clk(6);
      spi_cs_n = 1'b1;
      wait_clk(8);
   endtask

   // Scoreboard drain for one frame
   task automatic check_frame(input int nfull, input int part, input logic [15:0] exp_data,
                              input int b0, input int f0);
      check("pulse_count", br_cnt - b0, nfull);
      check("frame_error_count", fe_cnt - f0, (part > 0) ? 1 : 0);
      check("data_out", byte_data_received, exp_data);
      check("rx_queue_len", got_q.size(), nfull);
      for (int k = 0; k < nfull; k++) begin
         if (got_q.size() > 0 && exp_q.size() > 0)
            check("rx_word", got_q.pop_front(), exp_q.pop_front());
         if (lat_q.size() > 0)
            check("latency", lat_q.pop_front(), 3);
         check("miso_echo", frame_echo[k], exp_echo[k]);
      end
      got_q.delete();
      lat_q.delete();
      exp_q.delete();
   endtask

   typedef struct {
      logic [15:0] w0;
      logic [15:0] w1;
      int          nfull;
      int          part;
      logic [15:0] exp_data;
      logic [15:0] echo0;
      logic [15:0] echo1;
   } vec_t;

   vec_t vecs[5];

   initial begin
      int b0, f0, nfull, part;
      logic [15:0] model_last, prev, e;

      vecs[0] = '{16'h01A5, 16'h0000, 1, 0, 16'h01A5, 16'h0000, 16'h0000};
      vecs[1] = '{16'h0000, 16'h0000, 2, 0, 16'h0000, 16'h01A5, 16'h0000};
      vecs[2] = '{16'h0240, 16'h03FF, 2, 0, 16'h03FF, 16'h0000, 16'h0240};
      vecs[3] = '{16'h02C3, 16'h0000, 0, 9, 16'h03FF, 16'h0000, 16'h0000};
      vecs[4] = '{16'h0110, 16'h0000, 1, 0, 16'h0110, 16'h03FF, 16'h0000};

      // Reset held with SCK toggling
      for (int i = 0; i < 10; i++) begin
         spi_sck = ~spi_sck;
         wait_clk(1);
      end
      spi_sck = 1'b0;
      check("reset_data", byte_data_received, 16'h0000);
      check("reset_strobe", byte_received, 1'b0);
      check("reset_frame_error", frame_error, 1'b0);
      check("reset_miso", spi_miso, 1'b0);
      check("reset_pulses", br_cnt + fe_cnt, 0);
      rst_n = 1'b1;
      wait_clk(5);
      check("post_reset_data", byte_data_received, 16'h0000);
      check("post_reset_miso", spi_miso, 1'b0);

      // Table of frames
      for (int v = 0; v < 5; v++) begin
         frame_w[0] = vecs[v].w0;
         frame_w[1] = vecs[v].w1;
         exp_echo[0] = vecs[v].echo0;
         exp_echo[1] = vecs[v].echo1;
         for (int k = 0; k < vecs[v].nfull; k++) exp_q.push_back(frame_w[k]);
         b0 = br_cnt;
         f0 = fe_cnt;
         run_frame(vecs[v].nfull, vecs[v].part);
         check_frame(vecs[v].nfull, vecs[v].part, vecs[v].exp_data, b0, f0);
      end

      // Reset mid-word: partial word lost, no frame_error
      b0 = br_cnt;
      f0 = fe_cnt;
      spi_cs_n = 1'b0;
      wait_clk(6);
      spi_bits(16'h0310, 8, e);
      rst_n = 1'b0;
      wait_clk(3);
      check("midreset_data", byte_data_received, 16'h0000);
      check("midreset_miso", spi_miso, 1'b0);
      spi_cs_n = 1'b1;
      wait_clk(3);
      rst_n = 1'b1;
      wait_clk(8);
      check("midreset_pulses", br_cnt - b0, 0);
      check("midreset_no_error", fe_cnt - f0, 0);
      check("midreset_release_data", byte_data_received, 16'h0000);
      got_q.delete();
      lat_q.delete();
      frame_w[0] = 16'h0310;
      exp_echo[0] = 16'h0000;
      exp_q.push_back(16'h0310);
      b0 = br_cnt;
      f0 = fe_cnt;
      run_frame(1, 0);
      check_frame(1, 0, 16'h0310, b0, f0);

      // Random frames against a word-level model
      model_last = 16'h0310;
      for (int f = 0; f < 20; f++) begin
         nfull = $urandom_range(0, 3);
         part  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 15) : 0;
         if (nfull == 0 && part == 0) nfull = 1;
         if (nfull == 3) part = 0;
         for (int k = 0; k < 4; k++) frame_w[k] = 16'($urandom);
         prev = model_last;
         for (int k = 0; k < nfull; k++) begin
            exp_echo[k] = prev;
            prev = frame_w[k];
            exp_q.push_back(frame_w[k]);
         end
         model_last = prev;
         b0 = br_cnt;
         f0 = fe_cnt;
         run_frame(nfull, part);
         check_frame(nfull, part, model_last, b0, f0);
      end

      check("pulse_shape_violations", proto_err, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
